// File: rtl/tick_gen_multi.sv
// Multi-channel tick / clock-enable generator. Each channel runs its own
// terminal-count divider in periodic or one-shot mode and emits a tick and a square wave.
module tick_gen_multi #(
  parameter int                      NUM_CH    = 2,
  parameter int                      CNT_W     = 26,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT  = {26'd24_999, 26'd24_999_999},
  parameter logic [NUM_CH-1:0]       MODE_INIT = '0,
  parameter int                      CH_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave,
  output logic [NUM_CH-1:0] done,
  output logic              cfg_err
);

  localparam logic [31:0] NUM_CH_U = NUM_CH;

  logic cfg_bad;
  assign cfg_bad = cfg_we && (32'(cfg_ch) >= NUM_CH_U);

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_bad;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             mode_q;
    logic             tick_q;
    logic             wave_q;
    logic             done_q;
    logic             wr_hit;
    logic             restart;

    assign wr_hit  = cfg_we && (cfg_ch == CH_W'(i));
    assign restart = sync || wr_hit;

    // A restart beats a coincident terminal count, so no tick leaks out of
    // a partially completed period.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        mode_q <= MODE_INIT[i];
        tick_q <= 1'b0;
        wave_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        if (wr_hit) begin
          div_q  <= cfg_div;
          mode_q <= cfg_mode;
        end
        if (restart) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          wave_q <= 1'b0;
          done_q <= 1'b0;
        end else if (!en[i] || done_q) begin
          tick_q <= 1'b0;
        end else if (cnt_q == div_q) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          wave_q <= ~wave_q;
          if (mode_q) done_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign wave[i] = wave_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: a per-cycle vector table for the free-running
// case plus hand-written sequences for config writes, one-shot, freeze, sync and reset.
module tb_tick_gen_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] wave;
  logic [NUM_CH-1:0] done;
  logic              cfg_err;

  tick_gen_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({8'd1, 8'd2, 8'd4}),
    .MODE_INIT(3'b000),
    .CH_W     (CH_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .tick    (tick),
    .wave    (wave),
    .done    (done),
    .cfg_err (cfg_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst;
    logic [2:0]       en;
    logic             sync;
    logic [2:0]       exp_tick;
    logic [2:0]       exp_wave;
    logic [2:0]       exp_done;
    logic             exp_err;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  // Closed-form expectation for free-running channels with the reset divisors
  // {4,2,1}, k counted edges after reset/restart.
  function automatic logic [2:0] f_tick(input int k);
    int p[3] = '{5, 3, 2};
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = (k % p[c]) == 0;
    return r;
  endfunction

  function automatic logic [2:0] f_wave(input int k);
    int p[3] = '{5, 3, 2};
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = ((k / p[c]) % 2) == 1;
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; cfg_we = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset tick", 8'(tick), 8'h0);
    chk("reset wave", 8'(wave), 8'h0);
    chk("reset done", 8'(done), 8'h0);
    chk("reset err",  8'(cfg_err), 8'h0);
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (tick[ch]) break;
    end
  endtask

  task automatic chk_free(input string tag, input int k);
    chk($sformatf("%s k%0d tick", tag, k), 8'(tick), 8'(f_tick(k)));
    chk($sformatf("%s k%0d wave", tag, k), 8'(wave), 8'(f_wave(k)));
  endtask

  int n;
  int seen;
  logic [2:0] w_prev;

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

    // Vector table: two reset cycles, then 20 free-running cycles.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].en       = 3'b111;
      vecs[i].sync     = 1'b0;
      vecs[i].exp_done = 3'b000;
      vecs[i].exp_err  = 1'b0;
      if (i < 2) begin
        vecs[i].rst      = 1'b1;
        vecs[i].exp_tick = 3'b000;
        vecs[i].exp_wave = 3'b000;
      end else begin
        vecs[i].rst      = 1'b0;
        vecs[i].exp_tick = f_tick(i - 1);
        vecs[i].exp_wave = f_wave(i - 1);
      end
    end

    // Test 1: free running periods
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync;
      step();
      chk($sformatf("vec%0d tick", i), 8'(tick),    8'(vecs[i].exp_tick));
      chk($sformatf("vec%0d wave", i), 8'(wave),    8'(vecs[i].exp_wave));
      chk($sformatf("vec%0d done", i), 8'(done),    8'(vecs[i].exp_done));
      chk($sformatf("vec%0d err",  i), 8'(cfg_err), 8'(vecs[i].exp_err));
    end

    // Test 2: ch1 div=0 -> tick held high, wave toggles every cycle
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0;
    chk("t2 strobe tick1", 8'(tick[1]), 8'h0);
    chk("t2 strobe wave1", 8'(wave[1]), 8'h0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk($sformatf("t2 c%0d tick1", j), 8'(tick[1]), 8'h1);
      chk($sformatf("t2 c%0d wave1", j), 8'(wave[1]), 8'(j % 2));
    end

    // Test 3: ch0 one-shot div=3
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("t3 strobe tick0", 8'(tick[0]), 8'h0);
    chk("t3 strobe done0", 8'(done[0]), 8'h0);
    wait_tick(0, 10, n);
    chk("t3 fire latency", 8'(n), 8'd4);
    chk("t3 done0 set", 8'(done[0]), 8'h1);
    seen = 0;
    for (int j = 0; j < 50; j++) begin
      step();
      if (tick[0]) seen++;
    end
    chk("t3 halted ticks", 8'(seen), 8'd0);
    chk("t3 done0 held", 8'(done[0]), 8'h1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t3 rearm tick0", 8'(tick[0]), 8'h0);
    chk("t3 rearm done0", 8'(done[0]), 8'h0);
    wait_tick(0, 10, n);
    chk("t3 refire latency", 8'(n), 8'd4);
    chk("t3 done0 again", 8'(done[0]), 8'h1);

    // Test 4: freeze ch0 for 7 cycles at cnt=2
    do_reset();
    en = 3'b111;
    step();
    step();
    en = 3'b110;
    w_prev = wave;
    seen = 0;
    for (int j = 0; j < 7; j++) begin
      step();
      if (tick[0]) seen++;
      if (wave[0] !== w_prev[0]) seen++;
    end
    chk("t4 frozen activity", 8'(seen), 8'd0);
    en = 3'b111;
    wait_tick(0, 10, n);
    chk("t4 resume latency", 8'(n), 8'd3);
    chk("t4 wave0 after", 8'(wave[0]), 8'h1);

    // Test 5: bad channel write leaves everything running
    do_reset();
    en = 3'b111;
    for (int k = 1; k <= 3; k++) step();
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd0; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("t5 err pulse", 8'(cfg_err), 8'h1);
    chk_free("t5", 4);
    step();
    chk("t5 err clear", 8'(cfg_err), 8'h0);
    for (int k = 5; k <= 12; k++) begin
      if (k > 5) step();
      chk_free("t5", k);
    end
    chk("t5 done", 8'(done), 8'h0);

    // Test 6: sync on ch2 terminal count, then rst mid-period
    do_reset();
    en = 3'b111;
    step();
    chk_free("t6a", 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t6 sync tick", 8'(tick), 8'h0);
    chk("t6 sync wave", 8'(wave), 8'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_free("t6b", k);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 rst tick", 8'(tick), 8'h0);
    chk("t6 rst wave", 8'(wave), 8'h0);
    chk("t6 rst done", 8'(done), 8'h0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_free("t6c", k);
    end

    // Test 7: sync with a write in the same cycle, then write to a disabled channel
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd3; cfg_mode = 1'b0;
    step();
    sync = 1'b0; cfg_we = 1'b0;
    chk("t7 sync+we tick", 8'(tick), 8'h0);
    chk("t7 sync+we wave", 8'(wave), 8'h0);
    wait_tick(2, 10, n);
    chk("t7 ch2 new period", 8'(n), 8'd4);
    en = 3'b101;
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd1; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("t7 dis wave1", 8'(wave[1]), 8'h0);
    chk("t7 dis done1", 8'(done[1]), 8'h0);
    step();
    step();
    chk("t7 dis idle tick1", 8'(tick[1]), 8'h0);
    en = 3'b111;
    wait_tick(1, 10, n);
    chk("t7 ch1 oneshot latency", 8'(n), 8'd2);
    chk("t7 ch1 done", 8'(done[1]), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
